// File: rtl/l1buf_pkg.sv
// Shared types for the L1 hit buffer controller: read-engine states and pending-trigger entry.
// No logic; widths follow the default geometry used by every pixel readout.
package l1buf_pkg;

    localparam int ADDRWIDTH_DEF  = 7;
    localparam int TRIGDEPTH_DEF  = 4;
    localparam int EVCNTWIDTH_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [ADDRWIDTH_DEF-1:0]  rdAddr;
        logic [EVCNTWIDTH_DEF-1:0] evCnt;
    } trig_entry_t;

endpackage

// File: rtl/l1_hit_buffer_ctrl_if.sv
// Buffer-side SRAM controls plus the downstream valid/ready word; master = controller,
// slave = hit SRAM and downstream consumer.
interface l1_hit_buffer_ctrl_if #(
    parameter int ADDRWIDTH  = l1buf_pkg::ADDRWIDTH_DEF,
    parameter int EVCNTWIDTH = l1buf_pkg::EVCNTWIDTH_DEF
) ();

    logic                  wren;
    logic                  rden;
    logic [ADDRWIDTH-1:0]  wrAddr;
    logic [ADDRWIDTH-1:0]  rdAddr;
    logic                  memHit;
    logic                  memE1A;
    logic                  memE2A;
    logic                  outValid;
    logic                  outReady;
    logic                  outHit;
    logic                  outE1A;
    logic                  outE2A;
    logic [EVCNTWIDTH-1:0] outEvCnt;

    modport master (
        output wren, rden, wrAddr, rdAddr,
        output outValid, outHit, outE1A, outE2A, outEvCnt,
        input  memHit, memE1A, memE2A, outReady
    );

    modport slave (
        input  wren, rden, wrAddr, rdAddr,
        input  outValid, outHit, outE1A, outE2A, outEvCnt,
        output memHit, memE1A, memE2A, outReady
    );

endinterface

// File: rtl/l1_hit_buffer_ctrl_trig_fifo.sv
// Pending-trigger FIFO: head is combinational, push visible on the next cycle.
// No internal backpressure; the caller must not push when full unless popping in the same cycle.
module trig_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/l1_hit_buffer_ctrl.sv
// Circular write pointer plus L1A-driven read engine for the per-pixel hit SRAM buffer.
// L1A to outValid is 3 cycles when idle; outputs hold while outReady is low, triggers queue up to TRIGDEPTH.
module l1_hit_buffer_ctrl
    import l1buf_pkg::*;
#(
    parameter int ADDRWIDTH  = ADDRWIDTH_DEF,
    parameter int TRIGDEPTH  = TRIGDEPTH_DEF,
    parameter int EVCNTWIDTH = EVCNTWIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dis,
    input  logic                         L1A,
    input  logic [ADDRWIDTH-1:0]         latency,
    l1_hit_buffer_ctrl_if.master         bus,
    output logic                         trigOverflow,
    output logic [$clog2(TRIGDEPTH):0]   fifoLevel
);

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [EVCNTWIDTH-1:0] ev_cnt;
    logic [EVCNTWIDTH-1:0] rd_evcnt;
    logic                  trig_vld;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    trig_entry_t           push_dat;
    trig_entry_t           head_dat;

    assign trig_vld = L1A & ~dis;
    // A full FIFO still takes the trigger when the head leaves in the same cycle.
    assign push     = trig_vld & (~fifo_full | pop);

    always_comb begin
        push_dat        = '0;
        push_dat.rdAddr = bus.wrAddr - latency;
        push_dat.evCnt  = ev_cnt;
    end

    trig_fifo #(
        .DEPTH (TRIGDEPTH),
        .WIDTH ($bits(trig_entry_t))
    ) u_trig_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifoLevel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wren     <= 1'b0;
            bus.wrAddr   <= '0;
            ev_cnt       <= '0;
            trigOverflow <= 1'b0;
        end else begin
            bus.wren <= ~dis;
            if (!dis)              bus.wrAddr   <= bus.wrAddr + 1'b1;
            // Counting dropped triggers leaves a visible gap in delivered event numbers.
            if (trig_vld)          ev_cnt       <= ev_cnt + 1'b1;
            if (trig_vld && !push) trigOverflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!dis && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = RD;
                end
            end
            RD:  state_nxt = CAP;
            CAP: state_nxt = OUT;
            OUT: begin
                if (bus.outReady) begin
                    if (!dis && !fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = RD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rden     <= 1'b0;
            bus.rdAddr   <= '0;
            rd_evcnt     <= '0;
            bus.outHit   <= 1'b0;
            bus.outE1A   <= 1'b0;
            bus.outE2A   <= 1'b0;
            bus.outEvCnt <= '0;
        end else begin
            bus.rden <= pop;
            if (pop) begin
                bus.rdAddr <= head_dat.rdAddr;
                rd_evcnt   <= head_dat.evCnt;
            end
            if (state == CAP) begin
                bus.outHit   <= bus.memHit;
                bus.outE1A   <= bus.memE1A;
                bus.outE2A   <= bus.memE2A;
                bus.outEvCnt <= rd_evcnt;
            end
        end
    end

    assign bus.outValid = (state == OUT);

endmodule

// File: tb/tb_l1_hit_buffer_ctrl.sv
// Directed bench for l1_hit_buffer_ctrl with a behavioural hit SRAM (falling-edge write, rising-edge read).
module tb_l1_hit_buffer_ctrl;

    logic       clk;
    logic       reset;
    logic       dis;
    logic       L1A;
    logic [6:0] latency;
    logic       trigOverflow;
    logic [2:0] fifoLevel;
    logic       pix_hit;

    logic [6:0] exp_wa;
    logic       exp_wren;
    int         ncmp;
    int         nerr;
    int         n;

    logic mem_model [128];

    l1_hit_buffer_ctrl_if #(.ADDRWIDTH(7), .EVCNTWIDTH(12)) bus ();

    l1_hit_buffer_ctrl #(
        .ADDRWIDTH  (7),
        .TRIGDEPTH  (4),
        .EVCNTWIDTH (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dis          (dis),
        .L1A          (L1A),
        .latency      (latency),
        .bus          (bus),
        .trigOverflow (trigOverflow),
        .fifoLevel    (fifoLevel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.wren) mem_model[bus.wrAddr] <= pix_hit;
    end

    always @(posedge clk) begin
        if (bus.rden) bus.memHit <= mem_model[bus.rdAddr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (reset) begin
            exp_wa   = '0;
            exp_wren = 1'b0;
        end else begin
            exp_wren = ~dis;
            if (!dis) exp_wa = exp_wa + 7'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        L1A          = 1'b0;
        bus.outReady = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_wrAddr",       bus.wrAddr,   0);
        chk("rst_wren",         bus.wren,     0);
        chk("rst_rden",         bus.rden,     0);
        chk("rst_rdAddr",       bus.rdAddr,   0);
        chk("rst_outValid",     bus.outValid, 0);
        chk("rst_outHit",       bus.outHit,   0);
        chk("rst_outE1A",       bus.outE1A,   0);
        chk("rst_outE2A",       bus.outE2A,   0);
        chk("rst_outEvCnt",     bus.outEvCnt, 0);
        chk("rst_trigOverflow", trigOverflow, 0);
        chk("rst_fifoLevel",    fifoLevel,    0);
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.outValid !== 1'b1 && cnt < budget);
    endtask

    initial begin
        ncmp         = 0;
        nerr         = 0;
        exp_wa       = '0;
        exp_wren     = 1'b0;
        dis          = 1'b0;
        L1A          = 1'b0;
        latency      = 7'd100;
        pix_hit      = 1'b0;
        bus.outReady = 1'b0;
        bus.memE1A   = 1'b0;
        bus.memE2A   = 1'b0;

        // Free-running pointer, hit written at BC 150, L1A at BC 250
        do_reset();
        chk_reset_vals();
        for (int i = 0; i < 250; i++) begin
            chk("wrAddr_seq", bus.wrAddr, i % 128);
            chk("wren_seq",   bus.wren,   (i == 0) ? 0 : 1);
            chk("rden_quiet", bus.rden,   0);
            pix_hit = (i == 150);
            tick();
        end
        chk("wrAddr_bc250", bus.wrAddr, 122);
        L1A = 1'b1;
        tick();
        L1A = 1'b0;
        chk("lat_level1",   fifoLevel, 1);
        chk("lat_rden_k",   bus.rden,  0);
        tick();
        chk("lat_rden",     bus.rden,   1);
        chk("lat_rdAddr",   bus.rdAddr, 22);
        chk("lat_level0",   fifoLevel,  0);
        tick();
        chk("lat_rden_one", bus.rden,     0);
        chk("lat_noval",    bus.outValid, 0);
        tick();
        chk("lat_valid",    bus.outValid, 1);
        chk("lat_outHit",   bus.outHit,   1);
        chk("lat_evcnt",    bus.outEvCnt, 0);
        chk("lat_rdhold",   bus.rdAddr,   22);
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        chk("lat_accepted", bus.outValid, 0);

        // Overflow: six back-to-back L1As with downstream stalled
        do_reset();
        L1A = 1'b1;
        repeat (5) tick();
        chk("ovf_level_full", fifoLevel,    4);
        chk("ovf_not_yet",    trigOverflow, 0);
        tick();
        L1A = 1'b0;
        chk("ovf_level_hold", fifoLevel,    4);
        chk("ovf_sticky_set", trigOverflow, 1);
        chk("ovf_valid0",     bus.outValid, 1);
        chk("ovf_evcnt0",     bus.outEvCnt, 0);
        bus.outReady = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_valid(10, n);
            chk("ovf_b2b_gap",  n,            3);
            chk("ovf_evcnt_k",  bus.outEvCnt, k);
            chk("ovf_level_k",  fifoLevel,    4 - k);
        end
        tick();
        bus.outReady = 1'b0;
        chk("ovf_drained",  bus.outValid, 0);
        chk("ovf_level_0",  fifoLevel,    0);
        chk("ovf_still",    trigOverflow, 1);
        L1A = 1'b1;
        tick();
        L1A = 1'b0;
        wait_valid(10, n);
        chk("gap_lat",      n,            3);
        chk("gap_evcnt6",   bus.outEvCnt, 6);
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;

        // Wrap-around read address and ECC flag capture
        latency = 7'd10;
        do_reset();
        repeat (3) tick();
        chk("wrap_wrAddr3", bus.wrAddr, 3);
        L1A = 1'b1;
        tick();
        L1A = 1'b0;
        tick();
        chk("wrap_rden",    bus.rden,   1);
        chk("wrap_rdAddr",  bus.rdAddr, 121);
        tick();
        bus.memE1A = 1'b1;
        tick();
        bus.memE1A = 1'b0;
        chk("e1a_valid",    bus.outValid, 1);
        chk("e1a_set",      bus.outE1A,   1);
        chk("e1a_no_e2a",   bus.outE2A,   0);
        chk("e1a_evcnt",    bus.outEvCnt, 0);
        tick();
        tick();
        chk("e1a_hold_val", bus.outValid, 1);
        chk("e1a_hold",     bus.outE1A,   1);
        L1A = 1'b1;
        tick();
        L1A = 1'b0;
        bus.outReady = 1'b1;
        wait_valid(10, n);
        chk("e1a_next_gap",   n,            3);
        chk("e1a_next_clear", bus.outE1A,   0);
        chk("e1a_next_evcnt", bus.outEvCnt, 1);
        tick();
        bus.outReady = 1'b0;

        // dis during RD: in-flight word completes, L1A ignored, pending entry retained
        L1A = 1'b1;
        tick();
        tick();
        chk("dis_rden",      bus.rden,  1);
        chk("dis_level1",    fifoLevel, 1);
        dis = 1'b1;
        tick();
        L1A = 1'b0;
        chk("dis_l1a_drop",  fifoLevel, 1);
        chk("dis_wren",      bus.wren,  exp_wren);
        chk("dis_wren_lo",   bus.wren,  0);
        tick();
        chk("dis_deliver",   bus.outValid, 1);
        chk("dis_evcnt2",    bus.outEvCnt, 2);
        chk("dis_frozen",    bus.wrAddr,   exp_wa);
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        chk("dis_idle",      bus.outValid, 0);
        chk("dis_nopop",     bus.rden,     0);
        tick();
        chk("dis_nopop2",    bus.rden,     0);
        chk("dis_retained",  fifoLevel,    1);
        chk("dis_frozen2",   bus.wrAddr,   exp_wa);
        dis = 1'b0;
        tick();
        chk("dis_resume_rd", bus.rden,  1);
        chk("dis_resume_we", bus.wren,  1);
        chk("dis_resume_wa", bus.wrAddr, exp_wa);
        tick();
        tick();
        chk("dis_resume_val", bus.outValid, 1);
        chk("dis_evcnt3",     bus.outEvCnt, 3);
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;

        // Reset while a word with E2A is held and another trigger is pending
        bus.memE2A = 1'b1;
        L1A = 1'b1;
        tick();
        tick();
        L1A = 1'b0;
        tick();
        tick();
        bus.memE2A = 1'b0;
        chk("e2a_valid",   bus.outValid, 1);
        chk("e2a_set",     bus.outE2A,   1);
        chk("e2a_evcnt4",  bus.outEvCnt, 4);
        chk("e2a_pending", fifoLevel,    1);
        reset = 1'b1;
        tick();
        chk_reset_vals();
        reset = 1'b0;
        tick();
        chk("post_rst_wren", bus.wren, 1);
        chk("post_rst_rden", bus.rden, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
